// File: rtl/aes_decrypt_core_if.sv
// Purpose: bundles the round-key store link, the ciphertext/plaintext handshakes and the
//          external InvShiftRows+InvSubBytes link of aes_decrypt_core into one port.
// Latency: none; wires only.
// Backpressure: valid/ready on both block streams; the key store link is a pulse handshake.
//
// Ports, seen from the core (slave modport):
//   key_load_in/key_in        new cipher key request
//   key_init_out/key_data_out init pulse and key towards the key store
//   key_expanded_in           expansion-done pulse from the key store
//   key_round_rd_out/key_rd_in round-key address and same-cycle round key
//   valid_in/ready_out/ciphertext_in   ciphertext stream in
//   valid_out/ready_in/plaintext_out   plaintext stream out
//   inv_ss_state_out/inv_ss_state_in   external InvShiftRows+InvSubBytes unit
//   key_ready_out             an expanded key is available
interface aes_decrypt_core_if;
    logic         key_load_in;
    logic [127:0] key_in;
    logic         key_init_out;
    logic [127:0] key_data_out;
    logic         key_expanded_in;
    logic [3:0]   key_round_rd_out;
    logic [127:0] key_rd_in;
    logic         valid_in;
    logic         ready_out;
    logic [127:0] ciphertext_in;
    logic         valid_out;
    logic         ready_in;
    logic [127:0] plaintext_out;
    logic [127:0] inv_ss_state_out;
    logic [127:0] inv_ss_state_in;
    logic         key_ready_out;

    // Core side.
    modport slave (
        input  key_load_in, key_in, key_expanded_in, key_rd_in,
               valid_in, ciphertext_in, ready_in, inv_ss_state_in,
        output key_init_out, key_data_out, key_round_rd_out, ready_out,
               valid_out, plaintext_out, inv_ss_state_out, key_ready_out
    );

    // Environment side: key store, host datapath and the inverse S-box unit.
    modport master (
        output key_load_in, key_in, key_expanded_in, key_rd_in,
               valid_in, ciphertext_in, ready_in, inv_ss_state_in,
        input  key_init_out, key_data_out, key_round_rd_out, ready_out,
               valid_out, plaintext_out, inv_ss_state_out, key_ready_out
    );
endinterface

// File: rtl/aes_decrypt_core.sv
// Purpose: iterative AES-128 inverse cipher, one round per cycle, round keys read 10 down to 0.
// Latency: valid_out rises 10 cycles after the acceptance edge; one block per 12 cycles.
// Backpressure: ready_out only in IDLE; the result is held in OUTPUT until ready_in.
//
// Ports: clk_in, rst_in (synchronous, active high) plus the aes_decrypt_core_if slave bus.
// Byte 0 of every 128-bit word is bits [127:120]; column c is bits [127-32c -: 32].
// A key load in any state restarts key expansion and drops any block in flight.
module aes_decrypt_core (
    input  logic               clk_in,
    input  logic               rst_in,
    aes_decrypt_core_if.slave  bus
);

    typedef enum logic [2:0] {
        NO_KEY,
        EXPANDING,
        IDLE,
        ROUND,
        OUTPUT
    } fsm_t;

    fsm_t         fsm;
    logic [3:0]   round;
    logic [127:0] state_reg;
    logic [127:0] plaintext_q;
    logic [127:0] key_data_q;
    logic         valid_q;
    logic         key_init_q;
    logic         key_ready_q;

    logic [127:0] round_t;
    logic [127:0] inv_mix;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column of InvMixColumns; every product is an xor of the x2/x4/x8 chain.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // The external unit already applied InvShiftRows+InvSubBytes to state_reg.
    always_comb begin
        round_t = bus.inv_ss_state_in ^ bus.key_rd_in;
        inv_mix = {inv_mix_col(round_t[127:96]),
                   inv_mix_col(round_t[95:64]),
                   inv_mix_col(round_t[63:32]),
                   inv_mix_col(round_t[31:0])};
    end

    // Outside ROUND the address parks on key 10, which is what IDLE needs for acceptance.
    assign bus.key_round_rd_out = (fsm == ROUND) ? round : 4'd10;
    assign bus.ready_out        = (fsm == IDLE);
    assign bus.inv_ss_state_out = state_reg;
    assign bus.plaintext_out    = plaintext_q;
    assign bus.valid_out        = valid_q;
    assign bus.key_init_out     = key_init_q;
    assign bus.key_data_out     = key_data_q;
    assign bus.key_ready_out    = key_ready_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fsm         <= NO_KEY;
            round       <= 4'd0;
            state_reg   <= 128'h0;
            plaintext_q <= 128'h0;
            key_data_q  <= 128'h0;
            valid_q     <= 1'b0;
            key_init_q  <= 1'b0;
            key_ready_q <= 1'b0;
        end else begin
            key_init_q <= 1'b0;
            if (bus.key_load_in) begin
                // Wins over valid_in and abandons whatever block is in flight.
                key_data_q  <= bus.key_in;
                key_init_q  <= 1'b1;
                valid_q     <= 1'b0;
                key_ready_q <= 1'b0;
                fsm         <= EXPANDING;
            end else begin
                case (fsm)
                    NO_KEY: begin
                    end
                    EXPANDING: begin
                        // The done pulse lasts one cycle, so it is consumed right here.
                        if (bus.key_expanded_in) begin
                            key_ready_q <= 1'b1;
                            fsm         <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (bus.valid_in) begin
                            state_reg <= bus.ciphertext_in ^ bus.key_rd_in;
                            round     <= 4'd9;
                            fsm       <= ROUND;
                        end
                    end
                    ROUND: begin
                        if (round == 4'd0) begin
                            // Last round has no InvMixColumns.
                            plaintext_q <= round_t;
                            valid_q     <= 1'b1;
                            fsm         <= OUTPUT;
                        end else begin
                            state_reg <= inv_mix;
                            round     <= round - 4'd1;
                        end
                    end
                    OUTPUT: begin
                        if (bus.ready_in) begin
                            valid_q <= 1'b0;
                            fsm     <= IDLE;
                        end
                    end
                    default: fsm <= NO_KEY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Purpose: directed bench for aes_decrypt_core with a behavioural key store and inverse S-box unit.
// Latency: checks the 10-cycle result latency and the 12-cycle block interval.
// Backpressure: holds ready_in low after a result and checks the output stays frozen.
module tb_aes_decrypt_core;

    typedef logic [10:0][127:0] sched_t;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT3  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PT3  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT4  = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] PT4  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    logic clk_in = 1'b0;
    logic rst_in;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    aes_decrypt_core_if aif ();

    aes_decrypt_core dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (aif.slave)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // ---------------- GF(2^8) and S-box reference ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        logic [7:0] e;
        r    = 8'h01;
        base = a;
        e    = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_ss(input logic [127:0] s);
        logic [127:0] o;
        int si;
        int di;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                si = r + 4 * ((c - r + 4) % 4);
                di = r + 4 * c;
                o[127-8*di -: 8] = inv_sbox(s[127-8*si -: 8]);
            end
        end
        return o;
    endfunction

    function automatic sched_t expand_key(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        sched_t      s;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return s;
    endfunction

    // ---------------- Environment models ----------------
    sched_t       ks_rk;
    logic [127:0] ks_key;
    int           ks_cnt = 0;

    // Key store: captures the key on init, pulses expanded a few cycles later.
    always @(posedge clk_in) begin
        aif.key_expanded_in <= 1'b0;
        if (rst_in) begin
            ks_cnt <= 0;
        end else if (aif.key_init_out) begin
            ks_key <= aif.key_data_out;
            ks_cnt <= 6;
        end else if (ks_cnt == 1) begin
            ks_rk               <= expand_key(ks_key);
            aif.key_expanded_in <= 1'b1;
            ks_cnt              <= 0;
        end else if (ks_cnt > 1) begin
            ks_cnt <= ks_cnt - 1;
        end
    end

    assign aif.key_rd_in       = (aif.key_round_rd_out <= 4'd10) ? ks_rk[aif.key_round_rd_out] : 128'h0;
    assign aif.inv_ss_state_in = inv_ss(aif.inv_ss_state_out);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- Tests ----------------
    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        checks++; if (aif.ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready_out: got %b expected 0", aif.ready_out); end
        checks++; if (aif.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b expected 0", aif.valid_out); end
        checks++; if (aif.key_init_out !== 1'b0) begin errors++; $display("FAIL reset_key_init_out: got %b expected 0", aif.key_init_out); end
        checks++; if (aif.key_ready_out !== 1'b0) begin errors++; $display("FAIL reset_key_ready_out: got %b expected 0", aif.key_ready_out); end
        checks++; if (aif.key_data_out !== 128'h0) begin errors++; $display("FAIL reset_key_data_out: got %h expected 0", aif.key_data_out); end
        checks++; if (aif.plaintext_out !== 128'h0) begin errors++; $display("FAIL reset_plaintext_out: got %h expected 0", aif.plaintext_out); end
        checks++; if (aif.key_round_rd_out !== 4'd10) begin errors++; $display("FAIL reset_key_round_rd_out: got %0d expected 10", aif.key_round_rd_out); end
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_no_key();
        aif.valid_in      = 1'b1;
        aif.ciphertext_in = CT1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            checks++;
            if ({aif.ready_out, aif.valid_out, aif.key_round_rd_out} !== {1'b0, 1'b0, 4'd10}) begin
                errors++;
                $display("FAIL no_key_ignore: ready_out=%b valid_out=%b addr=%0d expected 0 0 10",
                         aif.ready_out, aif.valid_out, aif.key_round_rd_out);
            end
        end
        aif.valid_in = 1'b0;
    endtask

    task automatic load_key(input logic [127:0] k, input logic with_valid, input logic [127:0] ct, input string name);
        logic seen;
        aif.key_load_in   = 1'b1;
        aif.key_in        = k;
        aif.valid_in      = with_valid;
        aif.ciphertext_in = ct;
        @(negedge clk_in);
        aif.key_load_in = 1'b0;
        aif.valid_in    = 1'b0;
        aif.key_in      = ~k;
        checks++;
        if (aif.key_init_out !== 1'b1 || aif.key_data_out !== k) begin
            errors++;
            $display("FAIL %s_init: key_init_out=%b key_data_out=%h expected 1 %h", name, aif.key_init_out, aif.key_data_out, k);
        end
        checks++;
        if ({aif.key_ready_out, aif.ready_out, aif.valid_out} !== 3'b000) begin
            errors++;
            $display("FAIL %s_flags: key_ready_out=%b ready_out=%b valid_out=%b expected 0 0 0",
                     name, aif.key_ready_out, aif.ready_out, aif.valid_out);
        end
        @(negedge clk_in);
        checks++;
        if (aif.key_init_out !== 1'b0) begin
            errors++;
            $display("FAIL %s_init_pulse: key_init_out=%b expected 0", name, aif.key_init_out);
        end
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            checks++;
            if ({aif.key_ready_out, aif.ready_out, aif.valid_out} !== 3'b000) begin
                errors++;
                $display("FAIL %s_expanding: key_ready_out=%b ready_out=%b valid_out=%b expected 0 0 0",
                         name, aif.key_ready_out, aif.ready_out, aif.valid_out);
            end
            if (aif.key_expanded_in === 1'b1) seen = 1'b1;
            @(negedge clk_in);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_expand_timeout: key_expanded_in=0 expected a pulse within 60 cycles", name);
        end
        checks++;
        if ({aif.key_ready_out, aif.ready_out} !== 2'b11) begin
            errors++;
            $display("FAIL %s_key_ready: key_ready_out=%b ready_out=%b expected 1 1", name, aif.key_ready_out, aif.ready_out);
        end
    endtask

    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input int hold,
                             input string name, output int acc_cyc);
        int n;
        acc_cyc = -1;
        n = 0;
        while (aif.ready_out !== 1'b1 && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (aif.ready_out !== 1'b1 || aif.key_round_rd_out !== 4'd10) begin
            errors++;
            $display("FAIL %s_accept: ready_out=%b addr=%0d expected 1 10", name, aif.ready_out, aif.key_round_rd_out);
            return;
        end
        aif.ready_in      = (hold == 0);
        aif.valid_in      = 1'b1;
        aif.ciphertext_in = ct;
        acc_cyc           = cyc;
        @(negedge clk_in);
        aif.valid_in      = 1'b0;
        aif.ciphertext_in = ~ct;
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (aif.key_round_rd_out !== 4'(10 - k) || aif.valid_out !== 1'b0 || aif.ready_out !== 1'b0) begin
                errors++;
                $display("FAIL %s_round%0d: addr=%0d valid_out=%b ready_out=%b expected %0d 0 0",
                         name, k, aif.key_round_rd_out, aif.valid_out, aif.ready_out, 10 - k);
            end
            @(negedge clk_in);
        end
        checks++;
        if (aif.valid_out !== 1'b1 || aif.key_round_rd_out !== 4'd10) begin
            errors++;
            $display("FAIL %s_latency: valid_out=%b addr=%0d expected 1 10 at cycle 10", name, aif.valid_out, aif.key_round_rd_out);
        end
        checks++;
        if (aif.plaintext_out !== pt) begin
            errors++;
            $display("FAIL %s_plaintext: got %h expected %h", name, aif.plaintext_out, pt);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_in);
            checks++;
            if (aif.valid_out !== 1'b1 || aif.plaintext_out !== pt || aif.ready_out !== 1'b0) begin
                errors++;
                $display("FAIL %s_hold%0d: valid_out=%b ready_out=%b plaintext=%h expected 1 0 %h",
                         name, i, aif.valid_out, aif.ready_out, aif.plaintext_out, pt);
            end
        end
        aif.ready_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (aif.valid_out !== 1'b0 || aif.ready_out !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: valid_out=%b ready_out=%b expected 0 1", name, aif.valid_out, aif.ready_out);
        end
    endtask

    task automatic test_back_to_back();
        int a;
        int b;
        int c;
        run_block(CT3, PT3, 0, "b2b_first", a);
        run_block(CT4, PT4, 0, "b2b_second", b);
        run_block(CT2, PT2, 0, "b2b_third", c);
        checks++;
        if (b - a !== 12 || c - b !== 12) begin
            errors++;
            $display("FAIL b2b_interval: got %0d and %0d cycles expected 12 and 12", b - a, c - b);
        end
    endtask

    task automatic test_same_cycle();
        logic bad;
        int   acc;
        load_key(KEY1, 1'b1, CT1, "same_cycle");
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk_in);
            if (aif.valid_out !== 1'b0 || aif.ready_out !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL same_cycle_not_accepted: block was accepted alongside key load, expected IDLE with no result");
        end
        run_block(CT1, PT1, 0, "same_cycle_after", acc);
    endtask

    task automatic test_abort();
        int   n;
        logic bad;
        int   acc;
        n = 0;
        while (aif.ready_out !== 1'b1 && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        aif.valid_in      = 1'b1;
        aif.ciphertext_in = CT1;
        @(negedge clk_in);
        aif.valid_in = 1'b0;
        n = 0;
        while (aif.key_round_rd_out !== 4'd5 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (aif.key_round_rd_out !== 4'd5) begin
            errors++;
            $display("FAIL abort_reach_round5: addr=%0d expected 5", aif.key_round_rd_out);
        end
        load_key(KEY2, 1'b0, 128'h0, "abort");
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk_in);
            if (aif.valid_out !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_no_result: valid_out=1 seen for aborted block expected 0");
        end
        run_block(CT2, PT2, 0, "abort_new_key", acc);
    endtask

    task automatic test_reset_mid();
        logic bad;
        aif.valid_in      = 1'b1;
        aif.ciphertext_in = CT2;
        @(negedge clk_in);
        aif.valid_in = 1'b0;
        repeat (4) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        checks++;
        if ({aif.ready_out, aif.key_ready_out, aif.valid_out, aif.key_round_rd_out} !== {3'b000, 4'd10}) begin
            errors++;
            $display("FAIL reset_mid_state: ready_out=%b key_ready_out=%b valid_out=%b addr=%0d expected 0 0 0 10",
                     aif.ready_out, aif.key_ready_out, aif.valid_out, aif.key_round_rd_out);
        end
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk_in);
            if (aif.valid_out !== 1'b0 || aif.ready_out !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_mid_discard: block survived reset or core left NO_KEY");
        end
    endtask

    initial begin
        int acc;
        rst_in            = 1'b1;
        aif.key_load_in   = 1'b0;
        aif.key_in        = 128'h0;
        aif.valid_in      = 1'b0;
        aif.ciphertext_in = 128'h0;
        aif.ready_in      = 1'b1;

        test_reset();
        test_no_key();
        load_key(KEY1, 1'b0, 128'h0, "key1");
        run_block(CT1, PT1, 0, "fips_c1", acc);
        load_key(KEY2, 1'b0, 128'h0, "key2");
        run_block(CT2, PT2, 0, "fips_b", acc);
        run_block(CT2, PT2, 5, "backpressure", acc);
        test_back_to_back();
        test_same_cycle();
        test_abort();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_core.md
Name: aes_decrypt_core

Overview:
- Iterative AES-128 inverse-cipher engine.
- Reads the round-key store in descending order: key 10 down to key 0.
- Drives the key store's init/expansion handshake and sequences one round per cycle.
- Performs AddRoundKey and InvMixColumns internally; InvShiftRows+InvSubBytes comes from an external combinational unit.
- Sits between the AES key store and the host datapath, as the consumer side of the round-key interface.

Parameters:
- None. AES-128 only; 10 rounds fixed.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- key_load_in  in  1  pulse: load new cipher key
- key_in  in  128  cipher key, sampled when key_load_in=1
- key_init_out  out  1  one-cycle init pulse to key store init_in
- key_data_out  out  128  registered key to key store key_in
- key_expanded_in  in  1  one-cycle expansion-done pulse from key store
- key_round_rd_out  out  4  round-key read address; key store read is combinational
- key_rd_in  in  128  round key at key_round_rd_out, same cycle
- valid_in  in  1  ciphertext valid
- ready_out  out  1  core accepts ciphertext
- ciphertext_in  in  128  input block
- valid_out  out  1  plaintext valid
- ready_in  in  1  downstream accepts plaintext
- plaintext_out  out  128  output block
- inv_ss_state_out  out  128  current state to InvShiftRows+InvSubBytes unit
- inv_ss_state_in  in  128  combinational result from that unit
- key_ready_out  out  1  expanded key available

Behaviour:
- One clock; synchronous active-high reset.
- Byte order: bits [127:120] = byte 0; column c = bits [127-32c -: 32] (FIPS-197 column-major).
- States: NO_KEY, EXPANDING, IDLE, ROUND, OUTPUT.
- Reset: state NO_KEY; round counter 0.
- Reset values of outputs:
  - ready_out=0, valid_out=0, key_init_out=0, key_ready_out=0.
  - key_data_out=0, plaintext_out=0, key_round_rd_out=10.
- Reset mid-operation discards everything, including an in-flight block.
- key_load_in=1 in any state:
  - key_data_out<=key_in; key_init_out<=1 for exactly one cycle.
  - valid_out<=0, key_ready_out<=0; state<=EXPANDING.
  - Any in-flight block is discarded.
  - Has priority over valid_in in the same cycle.
- EXPANDING:
  - Wait for key_expanded_in=1, then state<=IDLE, key_ready_out<=1.
  - key_expanded_in is a single-cycle pulse and must be captured the cycle it occurs.
  - key_expanded_in is ignored in every other state.
- IDLE:
  - ready_out=1 (combinational from state); key_round_rd_out=10.
  - On valid_in&&ready_out: state_reg<=ciphertext_in^key_rd_in (k10); round<=9; state<=ROUND.
- ROUND (round r = 9..0):
  - key_round_rd_out=r; inv_ss_state_out=state_reg; t=inv_ss_state_in^key_rd_in.
  - r>0: state_reg<=InvMixColumns(t); r<=r-1.
  - r=0: plaintext_out<=t; valid_out<=1; state<=OUTPUT.
  - InvMixColumns: per column, matrix {0e,0b,0d,09}; GF(2^8) with poly 0x11b, built from xtime chains.
- OUTPUT:
  - valid_out and plaintext_out held stable until ready_in=1.
  - On ready_in=1: valid_out<=0; state<=IDLE.
  - ready_out=0 in OUTPUT, so no overlap with the next block.
- Latency:
  - Acceptance edge to valid_out high = 10 cycles.
  - With ready_in held 1, throughput = one block per 12 cycles.
- NO_KEY: valid_in ignored; ready_out=0.
- Address rule: key_round_rd_out is always in 0..10 and never undefined.

Test Plan:
- Reset, key load, FIPS-197 C.1 vector -> plaintext_out=00112233445566778899aabbccddeeff, valid_out exactly 10 cycles after acceptance.
  - Stimulus: key 000102030405060708090a0b0c0d0e0f with the real key store and a golden inv-S-box model; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
- Reload key 2b7e151628aed2a6abf7158809cf4f3c, then ciphertext 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734.
  - key_ready_out must be 0 throughout expansion and ready_out=0 until key_expanded_in.
- Backpressure: hold ready_in=0 for 5 cycles after valid_out -> plaintext_out stable, ready_out=0; release -> IDLE next cycle, ready_out=1.
- Abort: assert key_load_in at round 5 of a block -> valid_out never asserts for that block; key_init_out one-cycle pulse; new key expands.
- Ordering: valid_in before any key load -> no acceptance; valid_in and key_load_in in the same cycle -> key load wins, block not accepted.
- Address trace: key_round_rd_out sequence 10,9,8,...,0 across acceptance and rounds; back-to-back blocks both decrypt correctly.
